// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PARITY
    } piso_state_t;

    // Counter width wide enough to hold w itself (the counter parks at DATA_W, never wraps).
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bus of the serializer; master = upstream word source plus line consumer.
interface piso_serializer_if #(
    parameter int DATA_W = 8
);
    logic              ser_en;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              sdata;
    logic              out_valid;
    logic              out_last;
    logic              busy;

    modport master (
        output ser_en, in_valid, in_data,
        input  in_ready, sdata, out_valid, out_last, busy
    );

    modport slave (
        input  ser_en, in_valid, in_data,
        output in_ready, sdata, out_valid, out_last, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready intake and bit-rate enable.
// Define PISO_PARITY_EN to append a parity bit after each word's data bits.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter int   MSB_FIRST  = 0,
    parameter logic IDLE_LEVEL = 1'b0,
    parameter int   PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    piso_serializer_if.slave  bus
);

    localparam int            CW       = cnt_w(DATA_W);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

    if (DATA_W < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("piso_serializer: DATA_W must be >= 2 and PARITY_ODD must be 0 or 1");
    end

    piso_state_t       state, state_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt, shreg_shifted;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              sdata_q, sdata_nxt;
    logic              out_valid_q, out_valid_nxt;
    logic              out_last_q, out_last_nxt;
    logic              next_bit;
    logic              last_tick;
    logic              accept;
`ifdef PISO_PARITY_EN
    logic              par, par_nxt;
`endif

    assign next_bit      = (MSB_FIRST != 0) ? shreg[DATA_W-1] : shreg[0];
    assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[DATA_W-2:0], 1'b0}
                                            : {1'b0, shreg[DATA_W-1:1]};

    // The tick that emits a word's final bit is also the slot where the next word may enter.
`ifdef PISO_PARITY_EN
    assign last_tick = (state == ST_PARITY) && bus.ser_en;
`else
    assign last_tick = (state == ST_SHIFT) && bus.ser_en && (cnt == LAST_CNT);
`endif

    assign bus.in_ready  = (state == ST_IDLE) || last_tick;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.sdata     = sdata_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state != ST_IDLE);

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        cnt_nxt       = cnt;
        sdata_nxt     = sdata_q;
        out_valid_nxt = 1'b0;
        out_last_nxt  = 1'b0;
`ifdef PISO_PARITY_EN
        par_nxt       = par;
`endif

        case (state)
            ST_IDLE: begin
                // Returning to idle level on a tick keeps the previous last bit a full period.
                if (bus.ser_en) begin
                    sdata_nxt = IDLE_LEVEL;
                end
            end
            ST_SHIFT: begin
                if (bus.ser_en) begin
                    sdata_nxt     = next_bit;
                    shreg_nxt     = shreg_shifted;
                    cnt_nxt       = cnt + CW'(1);
                    out_valid_nxt = 1'b1;
                    if (cnt == LAST_CNT) begin
`ifdef PISO_PARITY_EN
                        state_nxt    = ST_PARITY;
`else
                        out_last_nxt = 1'b1;
                        state_nxt    = ST_IDLE;
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                if (bus.ser_en) begin
                    sdata_nxt     = par;
                    out_valid_nxt = 1'b1;
                    out_last_nxt  = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A new word overrides the shift update but the outgoing bit above still goes out.
        if (accept) begin
            shreg_nxt = bus.in_data;
            cnt_nxt   = '0;
            state_nxt = ST_SHIFT;
`ifdef PISO_PARITY_EN
            par_nxt   = (PARITY_ODD != 0) ? ~^bus.in_data : ^bus.in_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            cnt         <= '0;
            sdata_q     <= IDLE_LEVEL;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            cnt         <= cnt_nxt;
            sdata_q     <= sdata_nxt;
            out_valid_q <= out_valid_nxt;
            out_last_q  <= out_last_nxt;
`ifdef PISO_PARITY_EN
            par         <= par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: an LSB-first and an MSB-first serializer share one stimulus stream.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_en = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    initial forever #5 clk = ~clk;

    piso_serializer_if #(.DATA_W(8)) if_l ();
    piso_serializer_if #(.DATA_W(8)) if_m ();

    assign if_l.ser_en   = ser_en;
    assign if_l.in_valid = in_valid;
    assign if_l.in_data  = in_data;
    assign if_m.ser_en   = ser_en;
    assign if_m.in_valid = in_valid;
    assign if_m.in_data  = in_data;

    piso_serializer #(.DATA_W(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0), .PARITY_ODD(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .bus(if_l)
    );
    piso_serializer #(.DATA_W(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0), .PARITY_ODD(0)) dut_m (
        .clk(clk), .rst_n(rst_n), .bus(if_m)
    );

    typedef struct {
        logic sd;
        logic last;
        int   cyc;
    } obs_t;

    typedef struct {
        logic [7:0] data;
        int         period;
        logic [7:0] exp_lsb;
        logic [7:0] exp_msb;
        logic       exp_par;
    } vec_t;

    obs_t       q_l[$];
    obs_t       q_m[$];
    vec_t       vecs[7];
    int         cyc = 0;
    int         period = 1;
    int         phase = 0;
    logic       nv_valid = 1'b0;
    logic [7:0] nv_data = 8'h00;
    logic       acc;
    int         acc_edge = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (if_l.out_valid) q_l.push_back('{if_l.sdata, if_l.out_last, cyc});
        if (if_m.out_valid) q_m.push_back('{if_m.sdata, if_m.out_last, cyc});
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: inputs and ser_en change at negedge, acceptance judged just before posedge.
    task automatic step();
        @(negedge clk);
        in_valid = nv_valid;
        in_data  = nv_data;
        ser_en   = (phase == 0);
        phase    = (phase + 1) % period;
        #1;
        acc = in_valid && if_l.in_ready;
        @(posedge clk);
        #2;
        if (acc === 1'b1) acc_edge = cyc;
    endtask

    task automatic wait_acc(input string nm);
        int k = 0;
        step();
        while (acc !== 1'b1 && k < 60) begin
            step();
            k++;
        end
        chk({nm, "_accept"}, {31'b0, acc === 1'b1}, 32'd1);
    endtask

    task automatic wait_bits(input int n, input string nm);
        int k = 0;
        while ((q_l.size() < n || q_m.size() < n) && k < 400) begin
            step();
            k++;
        end
        chk({nm, "_bits_timeout"}, {31'b0, k < 400}, 32'd1);
    endtask

    function automatic logic [31:0] get_seq(input bit m, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) begin
            if (m && i < q_m.size()) r[i] = q_m[i].sd;
            if (!m && i < q_l.size()) r[i] = q_l[i].sd;
        end
        return r;
    endfunction

    function automatic logic [31:0] get_last(input bit m, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) begin
            if (m && i < q_m.size()) r[i] = q_m[i].last;
            if (!m && i < q_l.size()) r[i] = q_l[i].last;
        end
        return r;
    endfunction

    task automatic run_word(input logic [7:0] data, input int p, input string nm);
        period = p;
        phase  = 0;
        q_l.delete();
        q_m.delete();
        nv_valid = 1'b1;
        nv_data  = data;
        wait_acc(nm);
        nv_valid = 1'b0;
        wait_bits(NB, nm);
    endtask

    initial begin
        logic [31:0] el, em, e_last;
        logic [7:0]  words[2];
        int          acc_at[2];
        int          idx, k;

        vecs[0] = '{8'hA5, 1, 8'hA5, 8'hA5, 1'b0};
        vecs[1] = '{8'hC3, 3, 8'hC3, 8'hC3, 1'b0};
        vecs[2] = '{8'h12, 2, 8'h12, 8'h48, 1'b0};
        vecs[3] = '{8'h01, 1, 8'h01, 8'h80, 1'b1};
        vecs[4] = '{8'h0F, 1, 8'h0F, 8'hF0, 1'b0};
        vecs[5] = '{8'h07, 1, 8'h07, 8'hE0, 1'b1};
        vecs[6] = '{8'h03, 2, 8'h03, 8'hC0, 1'b0};

        rst_n = 1'b0;
        nv_valid = 1'b1;
        nv_data = 8'hFF;
        repeat (3) step();
        chk("reset_outputs",
            {24'b0, if_l.sdata, if_l.out_valid, if_l.out_last, if_l.busy,
             if_m.sdata, if_m.out_valid, if_m.out_last, if_m.busy}, 32'd0);
        nv_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("reset_idle_ready", {31'b0, if_l.in_ready}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_word(vecs[i].data, vecs[i].period, "vec");
`ifdef PISO_PARITY_EN
            el = {23'b0, vecs[i].exp_par, vecs[i].exp_lsb};
            em = {23'b0, vecs[i].exp_par, vecs[i].exp_msb};
`else
            el = {24'b0, vecs[i].exp_lsb};
            em = {24'b0, vecs[i].exp_msb};
`endif
            e_last = 32'd1 << (NB - 1);
            chk($sformatf("vec%0d_seq_lsb", i), get_seq(1'b0, NB), el);
            chk($sformatf("vec%0d_seq_msb", i), get_seq(1'b1, NB), em);
            chk($sformatf("vec%0d_last_lsb", i), get_last(1'b0, NB), e_last);
            chk($sformatf("vec%0d_last_msb", i), get_last(1'b1, NB), e_last);
            chk($sformatf("vec%0d_spacing", i), q_l[NB-1].cyc - q_l[0].cyc, (NB - 1) * vecs[i].period);
            if (vecs[i].period == 1)
                chk($sformatf("vec%0d_latency", i), q_l[0].cyc - acc_edge, 32'd1);
            repeat (2 * vecs[i].period + 2) step();
            chk($sformatf("vec%0d_idle", i),
                {28'b0, if_l.busy, if_l.sdata, if_m.busy, if_m.sdata}, 32'd0);
            chk($sformatf("vec%0d_count", i), q_l.size(), NB);
        end

        // Back-to-back words with in_valid held high throughout.
        period = 1;
        phase = 0;
        q_l.delete();
        q_m.delete();
        words[0] = 8'h01;
        words[1] = 8'h80;
        idx = 0;
        k = 0;
        nv_valid = 1'b1;
        nv_data = words[0];
        while (idx < 2 && k < 60) begin
            step();
            if (acc === 1'b1) begin
                acc_at[idx] = k;
                idx++;
                if (idx < 2) nv_data = words[idx];
                else nv_valid = 1'b0;
            end
            k++;
        end
        nv_valid = 1'b0;
        chk("b2b_accepts", idx, 32'd2);
        chk("b2b_accept_gap", acc_at[1] - acc_at[0], NB);
        wait_bits(2 * NB, "b2b");
`ifdef PISO_PARITY_EN
        chk("b2b_seq_lsb", get_seq(1'b0, 2 * NB), 32'h0003_0101);
        chk("b2b_seq_msb", get_seq(1'b1, 2 * NB), 32'h0002_0380);
        chk("b2b_last", get_last(1'b0, 2 * NB), 32'h0002_0100);
`else
        chk("b2b_seq_lsb", get_seq(1'b0, 2 * NB), 32'h0000_8001);
        chk("b2b_seq_msb", get_seq(1'b1, 2 * NB), 32'h0000_0180);
        chk("b2b_last", get_last(1'b0, 2 * NB), 32'h0000_8080);
`endif
        chk("b2b_no_gap", q_l[2*NB-1].cyc - q_l[0].cyc, 2 * NB - 1);
        repeat (4) step();

        // Reset in the middle of a word.
        period = 1;
        phase = 0;
        q_l.delete();
        q_m.delete();
        nv_valid = 1'b1;
        nv_data = 8'hFF;
        wait_acc("rst_mid");
        nv_valid = 1'b0;
        wait_bits(4, "rst_mid");
        rst_n = 1'b0;
        step();
        chk("rst_mid_outputs",
            {24'b0, if_l.sdata, if_l.out_valid, if_l.out_last, if_l.busy,
             if_m.sdata, if_m.out_valid, if_m.out_last, if_m.busy}, 32'd0);
        chk("rst_mid_bits", q_l.size(), 32'd4);
        chk("rst_mid_no_last", get_last(1'b0, q_l.size()), 32'd0);
        rst_n = 1'b1;
        step();
        run_word(8'h0F, 1, "post_rst");
`ifdef PISO_PARITY_EN
        chk("post_rst_seq_lsb", get_seq(1'b0, NB), 32'h0000_000F);
        chk("post_rst_seq_msb", get_seq(1'b1, NB), 32'h0000_00F0);
`else
        chk("post_rst_seq_lsb", get_seq(1'b0, NB), 32'h0000_000F);
        chk("post_rst_seq_msb", get_seq(1'b1, NB), 32'h0000_00F0);
`endif
        chk("post_rst_last", get_last(1'b0, NB), 32'd1 << (NB - 1));
        repeat (4) step();

        // Word offered while busy must wait for the last-bit tick, then go exactly once.
        period = 2;
        phase = 0;
        q_l.delete();
        q_m.delete();
        nv_valid = 1'b1;
        nv_data = 8'h55;
        wait_acc("hold_first");
        nv_valid = 1'b0;
        repeat (3) step();
        nv_valid = 1'b1;
        nv_data = 8'h3C;
        wait_acc("hold_second");
        nv_valid = 1'b0;
        chk("hold_on_last_tick", {30'b0, q_l[q_l.size()-1].last, q_l[q_l.size()-1].cyc == acc_edge}, 32'd3);
        chk("hold_bits_before", q_l.size(), NB);
        wait_bits(2 * NB, "hold");
        repeat (10) step();
        chk("hold_no_dup", q_l.size(), 2 * NB);
`ifdef PISO_PARITY_EN
        chk("hold_seq_lsb", get_seq(1'b0, 2 * NB), 32'h0000_7855);
        chk("hold_seq_msb", get_seq(1'b1, 2 * NB), 32'h0000_78AA);
        chk("hold_last", get_last(1'b0, 2 * NB), 32'h0002_0100);
`else
        chk("hold_seq_lsb", get_seq(1'b0, 2 * NB), 32'h0000_3C55);
        chk("hold_seq_msb", get_seq(1'b1, 2 * NB), 32'h0000_3CAA);
        chk("hold_last", get_last(1'b0, 2 * NB), 32'h0000_8080);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
